// File: rtl/sram_ctrl.sv
// Multi-beat SRAM controller: each DATA_W access becomes BEATS SRAM cycles of WAIT_CYCLES clocks.
// Optional address range check enabled by defining SRAM_RANGE_CHECK_EN.
module sram_ctrl #(
  parameter int DATA_W      = 32,
  parameter int SRAM_DW     = 16,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 5,
  parameter int BASE_ADDR   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [DATA_W-1:0]  write_data,
  output logic [DATA_W-1:0]  read_data,
  output logic               ready,
  output logic               err,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_we_n
);

  localparam int BEATS     = DATA_W / SRAM_DW;
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WAIT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int OFF_SHIFT = $clog2(DATA_W / 8);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t             state, state_d;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [DATA_W-1:0]  rd_buf, rd_assembled;
  logic               rejected;
  logic               req, reject, beat_end, last_cycle;
  logic [31:0]        offset;
  logic [39:0]        word_beats;

  assign req        = rd_en | wr_en;
  assign offset     = address - 32'(BASE_ADDR);
  assign word_beats = 40'(offset >> OFF_SHIFT) * 40'(BEATS);
  assign beat_end   = (wait_cnt == WAIT_W'(WAIT_CYCLES - 1));
  assign last_cycle = beat_end && (beat_cnt == BEAT_W'(BEATS - 1));

`ifdef SRAM_RANGE_CHECK_EN
  assign reject = (address < 32'(BASE_ADDR)) || (word_beats[39:SRAM_AW] != '0);
`else
  // Upper word bits are dropped on purpose: the SRAM address wraps.
  logic unused_range;
  assign reject       = 1'b0;
  assign unused_range = ^word_beats[39:SRAM_AW];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value unassigned (no latches).
    state_d      = state;
    ready        = 1'b0;
    err          = 1'b0;
    sram_we_n    = 1'b1;
    sram_dq_oe   = 1'b0;
    sram_addr    = '0;
    sram_dq_out  = '0;
    rd_assembled = rd_buf;
    rd_assembled[beat_cnt*SRAM_DW +: SRAM_DW] = sram_dq_in;

    unique case (state)
      IDLE: begin
        ready = !req;
        if (req) state_d = reject ? DONE : ACCESS;
      end
      ACCESS: begin
        sram_addr = SRAM_AW'(word_beats + 40'(beat_cnt));
        if (wr_en) begin
          sram_dq_oe  = 1'b1;
          sram_dq_out = write_data[beat_cnt*SRAM_DW +: SRAM_DW];
          // Strobe rises on the last cycle of each beat to give data hold time.
          sram_we_n   = beat_end;
        end
        if (last_cycle) state_d = DONE;
      end
      DONE: begin
        ready   = 1'b1;
        err     = rejected;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt  <= '0;
      wait_cnt  <= '0;
      rd_buf    <= '0;
      read_data <= '0;
      rejected  <= 1'b0;
    end else begin
      if (state == IDLE) rejected <= req && reject;
      if (state == ACCESS) begin
        if (beat_end) begin
          wait_cnt <= '0;
          beat_cnt <= last_cycle ? '0 : beat_cnt + BEAT_W'(1);
          if (!wr_en) begin
            rd_buf <= rd_assembled;
            // Final beat lands straight in read_data so it is visible during DONE.
            if (last_cycle) read_data <= rd_assembled;
          end
        end else begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
        end
      end else begin
        wait_cnt <= '0;
        beat_cnt <= '0;
      end
    end
  end

endmodule
